// File: rtl/memory_arbiter_pkg.sv
// pack: shared state/owner types and constants for memory_arbiter
package pack;
  typedef enum logic [1:0] {IDLE, INSTR_WAIT, DATA_WAIT} arbiterState_;
  typedef enum logic {OWNER_INSTR, OWNER_DATA} arbiterOwner_;
  localparam logic [3:0] MEM_BYTE_ENABLE_ALL = 4'hF;
endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between fetch and data, data has fixed priority.
// Define ARBITER_STARVE_GUARD_EN to force a fetch grant after MAX_DATA_STREAK data grants.
module memory_arbiter
  import pack::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instructionRequest,
  input  logic [ADDRESS_WIDTH-1:0] instructionAddress,
  output logic [31:0]              instructionData,
  output logic                     instructionDataValid,
  input  logic [ADDRESS_WIDTH-1:0] dataAddress,
  input  logic                     loadRequest,
  input  logic                     storeValid,
  input  logic [31:0]              storeData,
  input  logic [3:0]               byteEnable,
  output logic [31:0]              loadData,
  output logic                     loadDataValid,
  output logic                     storeComplete,
  output logic                     memRequest,
  output logic                     memWrite,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  output logic [31:0]              memWriteData,
  output logic [3:0]               memByteEnable,
  input  logic                     memReady,
  input  logic                     memResponseValid,
  input  logic [31:0]              memReadData
);
  arbiterState_ state;
  arbiterOwner_ winner;
  logic dataWants, fetchForced, grant, capturedWrite;
  logic [ADDRESS_WIDTH-1:0] capturedAddress, winnerAddress;
  if (MAX_DATA_STREAK < 1) begin : gBadStreak
    $error("MAX_DATA_STREAK must be at least 1");
  end
`ifdef ARBITER_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  logic [SW-1:0] streak;
  assign fetchForced = instructionRequest && streak == STREAK_MAX;
  always_ff @(posedge clock)
    if (reset) streak <= '0;
    else if (grant)
      streak <= winner == OWNER_INSTR ? '0 :
                (instructionRequest && streak != STREAK_MAX) ? streak + 1'b1 : streak;
`else
  assign fetchForced = 1'b0;
`endif
  assign dataWants = loadRequest || storeValid;
  assign winner = (dataWants && !fetchForced) ? OWNER_DATA : OWNER_INSTR;
  assign winnerAddress = winner == OWNER_DATA ? dataAddress : instructionAddress;
  assign memRequest = state == IDLE && (dataWants || instructionRequest);
  // store beats a simultaneous load because memWrite follows storeValid directly
  assign memWrite = memRequest && winner == OWNER_DATA && storeValid;
  assign memAddress = memRequest ? {winnerAddress[ADDRESS_WIDTH-1:2], 2'b00} : '0;
  assign memWriteData = memWrite ? storeData : '0;
  assign memByteEnable = memWrite ? byteEnable : MEM_BYTE_ENABLE_ALL;
  assign grant = memRequest && memReady;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      capturedAddress <= '0;
      capturedWrite <= 1'b0;
      instructionData <= '0;
      instructionDataValid <= 1'b0;
      loadData <= '0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
    end else begin
      instructionDataValid <= 1'b0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      case (state)
        IDLE:
          if (grant) begin
            state <= winner == OWNER_DATA ? DATA_WAIT : INSTR_WAIT;
            capturedAddress <= winnerAddress;
            capturedWrite <= memWrite;
          end
        INSTR_WAIT:
          if (memResponseValid) begin
            state <= IDLE;
            // a redirected or withdrawn fetch silently drops its response
            if (instructionRequest && instructionAddress == capturedAddress) begin
              instructionData <= memReadData;
              instructionDataValid <= 1'b1;
            end
          end
        DATA_WAIT:
          if (memResponseValid) begin
            state <= IDLE;
            if (capturedWrite) storeComplete <= 1'b1;
            else begin
              loadData <= memReadData;
              loadDataValid <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clock)
    if (!reset) assert (!(loadRequest && storeValid));
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed self-checking bench for memory_arbiter (honours ARBITER_STARVE_GUARD_EN).
module tb_memory_arbiter;
  logic clock = 1'b0, reset;
  logic instructionRequest, loadRequest, storeValid, memReady, memResponseValid;
  logic [31:0] instructionAddress, dataAddress, storeData, memReadData;
  logic [3:0] byteEnable;
  logic [31:0] instructionData, loadData, memAddress, memWriteData;
  logic instructionDataValid, loadDataValid, storeComplete, memRequest, memWrite;
  logic [3:0] memByteEnable;
  int checks = 0, errors = 0;
`ifdef ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  memory_arbiter dut (
    .clock(clock), .reset(reset),
    .instructionRequest(instructionRequest), .instructionAddress(instructionAddress),
    .instructionData(instructionData), .instructionDataValid(instructionDataValid),
    .dataAddress(dataAddress), .loadRequest(loadRequest), .storeValid(storeValid),
    .storeData(storeData), .byteEnable(byteEnable),
    .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memByteEnable(memByteEnable),
    .memReady(memReady), .memResponseValid(memResponseValid), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    instructionRequest = 1'b0; instructionAddress = '0;
    loadRequest = 1'b0; storeValid = 1'b0; dataAddress = '0;
    storeData = '0; byteEnable = '0;
    memReady = 1'b0; memResponseValid = 1'b0; memReadData = '0;
    step(); step();
    chk("rst_memRequest", 32'(memRequest), 32'd0);
    chk("rst_memByteEnable", 32'(memByteEnable), 32'hF);
    chk("rst_memAddress", memAddress, 32'h0);
    chk("rst_pulses", {29'd0, instructionDataValid, loadDataValid, storeComplete}, 32'd0);
    chk("rst_data", instructionData | loadData, 32'h0);
    reset = 1'b0;
    step();

    // fetch only, 2-cycle memory latency
    instructionRequest = 1'b1; instructionAddress = 32'h100; memReady = 1'b1; #1;
    chk("f_memRequest", 32'(memRequest), 32'd1);
    chk("f_memAddress", memAddress, 32'h100);
    chk("f_memWrite", 32'(memWrite), 32'd0);
    chk("f_memByteEnable", 32'(memByteEnable), 32'hF);
    step();
    memReady = 1'b0; #1;
    chk("f_wait_noRequest", 32'(memRequest), 32'd0);
    step();
    memResponseValid = 1'b1; memReadData = 32'h00500093;
    step();
    memResponseValid = 1'b0;
    chk("f_valid", 32'(instructionDataValid), 32'd1);
    chk("f_data", instructionData, 32'h00500093);
    instructionRequest = 1'b0;
    step();
    chk("f_valid_oneCycle", 32'(instructionDataValid), 32'd0);
    chk("f_data_hold", instructionData, 32'h00500093);

    // fetch and load together: load first
    instructionRequest = 1'b1; instructionAddress = 32'h240;
    loadRequest = 1'b1; dataAddress = 32'h200; memReady = 1'b1; #1;
    chk("fl_loadWins", memAddress, 32'h200);
    chk("fl_read", 32'(memWrite), 32'd0);
    step();
    memReady = 1'b0; memResponseValid = 1'b1; memReadData = 32'hDEADBEEF;
    step();
    chk("fl_loadValid", 32'(loadDataValid), 32'd1);
    chk("fl_loadData", loadData, 32'hDEADBEEF);
    chk("fl_noInstrValid", 32'(instructionDataValid), 32'd0);
    loadRequest = 1'b0; memResponseValid = 1'b0; memReady = 1'b1; #1;
    chk("fl_fetchNext_req", 32'(memRequest), 32'd1);
    chk("fl_fetchNext_addr", memAddress, 32'h240);
    step();
    memReady = 1'b0; memResponseValid = 1'b1; memReadData = 32'h11112222;
    step();
    chk("fl_instrValid", 32'(instructionDataValid), 32'd1);
    chk("fl_instrData", instructionData, 32'h11112222);
    chk("fl_loadValid_oneCycle", 32'(loadDataValid), 32'd0);
    instructionRequest = 1'b0; memResponseValid = 1'b0;

    // store with partial lanes
    storeValid = 1'b1; dataAddress = 32'h304; storeData = 32'hCAFEF00D;
    byteEnable = 4'b0011; memReady = 1'b1; #1;
    chk("st_memWrite", 32'(memWrite), 32'd1);
    chk("st_memAddress", memAddress, 32'h304);
    chk("st_memByteEnable", 32'(memByteEnable), 32'h3);
    chk("st_memWriteData", memWriteData, 32'hCAFEF00D);
    step();
    memReady = 1'b0; memResponseValid = 1'b1; memReadData = 32'h0;
    step();
    chk("st_complete", 32'(storeComplete), 32'd1);
    chk("st_noLoadValid", 32'(loadDataValid), 32'd0);
    chk("st_loadData_hold", loadData, 32'hDEADBEEF);
    storeValid = 1'b0; memResponseValid = 1'b0;
    step();
    chk("st_complete_oneCycle", 32'(storeComplete), 32'd0);

    // unaligned load address and re-evaluation while memReady=0
    loadRequest = 1'b1; dataAddress = 32'h207; #1;
    chk("al_memAddress", memAddress, 32'h204);
    chk("al_memByteEnable", 32'(memByteEnable), 32'hF);
    step();
    loadRequest = 1'b0; instructionRequest = 1'b1; instructionAddress = 32'h100; #1;
    chk("re_winnerChanges", memAddress, 32'h100);

    // branch redirect drops the stale fetch
    memReady = 1'b1;
    step();
    memReady = 1'b0; instructionAddress = 32'h180;
    step();
    memResponseValid = 1'b1; memReadData = 32'hBAD0BAD0;
    step();
    chk("rd_dropped", 32'(instructionDataValid), 32'd0);
    chk("rd_data_hold", instructionData, 32'h11112222);
    memResponseValid = 1'b0; memReady = 1'b1; #1;
    chk("rd_newAddr", memAddress, 32'h180);
    step();
    memReady = 1'b0; memResponseValid = 1'b1; memReadData = 32'h00A00113;
    step();
    chk("rd_valid", 32'(instructionDataValid), 32'd1);
    chk("rd_data", instructionData, 32'h00A00113);
    instructionRequest = 1'b0; memResponseValid = 1'b0;

    // response in IDLE is ignored
    memResponseValid = 1'b1; memReadData = 32'h12345678;
    step();
    memResponseValid = 1'b0;
    chk("idle_resp_ignored", {29'd0, instructionDataValid, loadDataValid, storeComplete}, 32'd0);

    // continuous loads with a pending fetch
    loadRequest = 1'b1; dataAddress = 32'h400;
    instructionRequest = 1'b1; instructionAddress = 32'h500;
    for (int i = 0; i < 6; i++) begin
      memReady = 1'b1; #1;
      chk($sformatf("sv_grant%0d", i), memAddress, (GUARD && i == 4) ? 32'h500 : 32'h400);
      step();
      memReady = 1'b0; memResponseValid = 1'b1; memReadData = 32'h1000 + i;
      step();
      memResponseValid = 1'b0;
    end
    loadRequest = 1'b0; instructionRequest = 1'b0;
    step();

    // reset during DATA_WAIT
    loadRequest = 1'b1; dataAddress = 32'h600; memReady = 1'b1;
    step();
    memReady = 1'b0; loadRequest = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("rw_noLoadValid", 32'(loadDataValid), 32'd0);
    chk("rw_loadData", loadData, 32'h0);
    chk("rw_instrData", instructionData, 32'h0);
    chk("rw_memRequest", 32'(memRequest), 32'd0);
    chk("rw_memByteEnable", 32'(memByteEnable), 32'hF);
    loadRequest = 1'b1; dataAddress = 32'h700; #1;
    chk("rw_idle_issue", 32'(memRequest), 32'd1);
    step();
    chk("rw_noPulseLater", 32'(loadDataValid), 32'd0);
    loadRequest = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one single-ported unified memory between the instruction-fetch port (driven by Fetch) and the data port (driven by Memory), replacing separate Imem/Dmem instances in Top. It presents Imem-style and Dmem-style interfaces upstream and one request/response port downstream. Arbitration gives data fixed priority, with an optional anti-starvation guard for fetch. Exactly one memory transaction is outstanding at any time.

## Interface
- ADDRESS_WIDTH, 32, byte-address width on all ports
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (used only with guard enabled)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state is cleared on the rising edge of clock while reset=1
- instructionRequest  in  1  fetch wants instruction at instructionAddress
- instructionAddress  in  ADDRESS_WIDTH  fetch PC
- instructionData  out  32  fetched word
- instructionDataValid  out  1  one-cycle pulse; instructionData valid
- dataAddress  in  ADDRESS_WIDTH  load/store address from Memory stage
- loadRequest  in  1  load pending
- storeValid  in  1  store pending
- storeData  in  32  store word, already lane-aligned
- byteEnable  in  4  store byte lanes
- loadData  out  32  loaded word
- loadDataValid  out  1  one-cycle pulse
- storeComplete  out  1  one-cycle pulse
- memRequest  out  1  issue transaction
- memWrite  out  1  1=store, 0=read
- memAddress  out  ADDRESS_WIDTH  word-aligned address ([1:0] forced 0)
- memWriteData  out  32  store word
- memByteEnable  out  4  lanes; 4'hF on reads
- memReady  in  1  memory accepts memRequest this cycle
- memResponseValid  in  1  read data or write acknowledge
- memReadData  in  32  read data

## Operation
- States: IDLE, INSTR_WAIT, DATA_WAIT.
- IDLE: select a winner combinationally. The data port wins if loadRequest|storeValid; otherwise fetch wins if instructionRequest. Assert memRequest with the winner's fields.
  - If memReady=1: capture owner, op and address; go to INSTR_WAIT or DATA_WAIT.
  - If memReady=0: hold memRequest and stay in IDLE. The winner is re-evaluated each cycle.
- loadRequest and storeValid both high: the store wins. This combination is flagged by an assertion.
- INSTR_WAIT, on memResponseValid:
  - If instructionRequest is still high and instructionAddress equals the captured address: register memReadData to instructionData and pulse instructionDataValid.
  - Otherwise (branch redirect or fetch withdrawn): drop the response, no pulse.
  - Return to IDLE in both cases.
- DATA_WAIT, on memResponseValid:
  - Read: register loadData and pulse loadDataValid.
  - Write: pulse storeComplete.
  - Return to IDLE.
- Requesters hold their request and fields stable until their response pulse. The data port is never aborted.
- memResponseValid in IDLE is ignored.
- Streak counter: 0..MAX_DATA_STREAK. It increments on each data grant while instructionRequest=1 and clears on any instruction grant.

## Timing
- Reset values: all outputs 0 except memByteEnable=4'hF; state=IDLE; streak=0.
- Reset while in INSTR_WAIT or DATA_WAIT returns to IDLE. No response pulse is produced for the in-flight transaction. The memory is reset by the same reset.
- Request accepted at cycle T and memory response at T+L: the upstream pulse occurs at T+L+1. The arbiter is in IDLE at T+L+1 and may issue the next transaction in that same cycle.
- Response pulses are exactly one cycle wide. loadData and instructionData hold their value until the next pulse.

## Configuration
- ARBITER_STARVE_GUARD_EN defined:
  - In IDLE, if streak==MAX_DATA_STREAK and instructionRequest=1, fetch wins over data for one grant.
  - The streak counter then clears.
- ARBITER_STARVE_GUARD_EN undefined:
  - Strict data priority; the streak counter is not synthesized.
  - Fetch can starve while data requests continue.

## Structure
- Shared package pack holds:
  - typedef enum arbiterState_ {IDLE, INSTR_WAIT, DATA_WAIT}
  - typedef enum arbiterOwner_ {OWNER_INSTR, OWNER_DATA}
  - constant MEM_BYTE_ENABLE_ALL = 4'hF
- Single module, no sub-module: the FSM, capture registers and streak counter fit comfortably in one block.

## Test plan
- Fetch only: instructionRequest=1 to 0x100, memory returns 0x00500093 after 2 cycles -> instructionDataValid one cycle later with instructionData=0x00500093.
- Fetch and load asserted in the same cycle at 0x200 -> load issued first, loadDataValid pulses; the fetch issues in the IDLE cycle after that pulse.
- Store to 0x304 with byteEnable=4'b0011 -> memWrite=1, memAddress=0x304, memByteEnable=4'b0011, single storeComplete pulse.
- Fetch to 0x100, then instructionAddress changes to 0x180 before the response -> no pulse for 0x100; 0x180 is requested next and delivered.
- With ARBITER_STARVE_GUARD_EN: continuous loads plus a pending fetch -> fetch granted after exactly 4 data grants. Without the macro: fetch never granted while loads continue.
- Reset asserted during DATA_WAIT -> no loadDataValid; all outputs return to reset values and state is IDLE the next cycle.
